// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
//   Constants and types shared by the instruction fetch unit and its users:
//   instruction/address widths, the default halt word (program-memory fill
//   value) and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int INSTR_W = 18;
    localparam int ADDR_W  = 8;

    // Unprogrammed memory reads back this word, so fetching stops on it.
    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 18'h001FF;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE   = 2'd0;
    localparam fetch_state_t ST_FETCH  = 2'd1;
    localparam fetch_state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch
//   Sequential instruction fetch unit. Holds the PC, drives it straight out
//   as the program-memory address, captures the returned word into an
//   output register and hands it to the consumer with a valid/ready
//   handshake. Fetching stops on HALT_WORD and restarts on a branch.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   start         in   leave IDLE and begin fetching (ignored elsewhere)
//   address       out  program-memory address (== PC, registered)
//   mem_out       in   program-memory word for `address`, same cycle
//   instr         out  captured instruction
//   instr_pc      out  address `instr` was fetched from
//   instr_valid   out  instr/instr_pc hold an unconsumed instruction
//   instr_ready   in   consumer accepts instr this cycle
//   branch_en     in   redirect fetch to branch_target (FETCH/HALTED only)
//   branch_target in   redirect address
//   halted        out  FSM is in HALTED
//   dbg_state     out  raw FSM state for observation
//
// Handshake: a word transfers on every rising edge where instr_valid=1 and
// instr_ready=1. While instr_valid=1 and instr_ready=0 the producer holds
// instr/instr_pc stable. instr_ready may be high with instr_valid low; that
// cycle transfers nothing.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 8'd0,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] mem_out,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted,
    output fetch_state_t       dbg_state
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;

    logic accept;
    assign accept = valid_q & instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        // A consumed word leaves the register empty unless refilled below.
        valid_d    = valid_q & ~accept;

        if (branch_en && state_q != ST_IDLE) begin
            // Branch wins over everything: flush, redirect, no capture.
            pc_d    = branch_target;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!valid_q || instr_ready) begin
                        instr_d    = mem_out;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        if (mem_out == HALT_WORD) begin
                            // PC parks on the halt word's address.
                            state_d = ST_HALTED;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    // No captures; the pending halt word drains normally.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Directed bench for instr_fetch. Stimulus pushes expected {instr_pc,
//   instr} pairs into exp_q; a monitor pops one on every accepted transfer.
//   Register-level properties (reset values, freeze, halt, flush) are
//   checked directly by the stimulus process.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] mem_out;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic               halted;
    fetch_state_t       dbg_state;

    logic [INSTR_W-1:0] mem [256];
    assign mem_out = mem[address];

    logic [25:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .address       (address),
        .mem_out       (mem_out),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halted        (halted),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc, input logic [17:0] w);
        exp_q.push_back({pc, w});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " address"}, 32'(address), 32'h0);
        chk({tag, " instr"}, 32'(instr), 32'h0);
        chk({tag, " instr_pc"}, 32'(instr_pc), 32'h0);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, " halted"}, 32'(halted), 32'h0);
    endtask

    task automatic wait_halted(input string tag);
        int n;
        n = 0;
        while (!halted && n < 40) begin
            step();
            n++;
        end
        chk({tag, " reached_halt"}, 32'(halted), 32'h1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=0x%0h instr=0x%0h expected nothing", instr_pc, instr);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    failures++;
                    $display("FAIL sb_word: got pc=0x%0h instr=0x%0h expected pc=0x%0h instr=0x%0h",
                             instr_pc, instr, e[25:18], e[17:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 18'h00100 + 18'(k);
        mem[5]   = 18'h001FF;   // halt word
        mem[255] = 18'h2AAFF;   // keeps the wrap test from halting at FF

        reset = 1'b1; start = 1'b1; branch_en = 1'b1;
        branch_target = 8'h33; instr_ready = 1'b1;
        step();
        step();
        chk_reset_vals("rst0");
        reset = 1'b0; start = 1'b0; branch_en = 1'b0;
        step();
        step();
        chk("idle_no_start valid", 32'(instr_valid), 32'h0);
        chk("idle_no_start address", 32'(address), 32'h0);

        // Sequential stream 0..5, halt word at 5.
        for (int k = 0; k < 5; k++) push(8'(k), 18'h00100 + 18'(k));
        push(8'd5, 18'h001FF);
        start = 1'b1;
        step();                      // edge N: IDLE -> FETCH
        start = 1'b0;
        chk("latency edgeN valid", 32'(instr_valid), 32'h0);
        step();                      // edge N+1: first capture
        chk("latency edgeN1 valid", 32'(instr_valid), 32'h1);
        chk("first instr", 32'(instr), 32'h00100);
        chk("first instr_pc", 32'(instr_pc), 32'h0);
        step();
        chk("second instr_pc", 32'(instr_pc), 32'h1);
        step();
        chk("third instr_pc", 32'(instr_pc), 32'h2);

        // Backpressure while pc 2 is presented.
        instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp instr", 32'(instr), 32'h00102);
            chk("bp instr_pc", 32'(instr_pc), 32'h2);
            chk("bp address", 32'(address), 32'h3);
            chk("bp valid", 32'(instr_valid), 32'h1);
        end
        instr_ready = 1'b1;
        wait_halted("run1");
        chk("halt instr", 32'(instr), 32'h001FF);
        chk("halt instr_pc", 32'(instr_pc), 32'h5);
        chk("halt address", 32'(address), 32'h5);
        step();
        step();
        chk("halt drained valid", 32'(instr_valid), 32'h0);
        chk("halt still halted", 32'(halted), 32'h1);
        chk("halt address hold", 32'(address), 32'h5);

        // Branch out of HALTED to 0x40.
        push(8'h40, 18'h00140);
        push(8'h41, 18'h00141);
        branch_en = 1'b1; branch_target = 8'h40;
        step();
        branch_en = 1'b0;
        chk("br_halt valid", 32'(instr_valid), 32'h0);
        chk("br_halt halted", 32'(halted), 32'h0);
        chk("br_halt address", 32'(address), 32'h40);
        step();
        chk("br_halt first pc", 32'(instr_pc), 32'h40);
        step();
        step();
        chk("br_halt third pc", 32'(instr_pc), 32'h42);

        // Branch while a word is pending and not accepted: 0x42 is flushed.
        instr_ready = 1'b0;
        branch_en = 1'b1; branch_target = 8'h80;
        step();
        branch_en = 1'b0;
        chk("br_flush valid", 32'(instr_valid), 32'h0);
        step();
        chk("br_flush target pc", 32'(instr_pc), 32'h80);
        chk("br_flush target instr", 32'(instr), 32'h00180);

        // Branch together with accept: 0x80 is consumed, then flush to FE.
        push(8'h80, 18'h00180);
        push(8'hFE, 18'h001FE);
        push(8'hFF, 18'h2AAFF);
        push(8'h00, 18'h00100);
        instr_ready = 1'b1;
        branch_en = 1'b1; branch_target = 8'hFE;
        step();
        branch_en = 1'b0;
        chk("br_accept valid", 32'(instr_valid), 32'h0);
        step();
        chk("wrap pc FE", 32'(instr_pc), 32'hFE);
        step();
        chk("wrap pc FF", 32'(instr_pc), 32'hFF);
        step();
        chk("wrap pc 00", 32'(instr_pc), 32'h00);
        step();
        instr_ready = 1'b0;
        chk("wrap pc 01", 32'(instr_pc), 32'h01);
        chk("wrap halted", 32'(halted), 32'h0);

        // Reset mid-stream with a pending word.
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        chk_reset_vals("rst_mid");
        step();
        step();
        chk("rst_mid idle valid", 32'(instr_valid), 32'h0);
        chk("rst_mid idle address", 32'(address), 32'h0);

        // Run to halt again, then reset while HALTED with the halt word pending.
        for (int k = 0; k < 5; k++) push(8'(k), 18'h00100 + 18'(k));
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_halted("run2");
        instr_ready = 1'b0;
        chk("run2 halt pending", 32'(instr_valid), 32'h1);
        reset = 1'b1; branch_en = 1'b1; branch_target = 8'h77;
        step();
        reset = 1'b0; branch_en = 1'b0;
        chk_reset_vals("rst_halt");
        step();
        step();
        chk("rst_halt idle valid", 32'(instr_valid), 32'h0);
        chk("rst_halt idle address", 32'(address), 32'h0);

        chk("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
